// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmitter: start, 8 data bits LSB first, optional even parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN for a 4-entry byte FIFO; otherwise a single holding register is used.
module uart_tx_sb_ctrl #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int RESET_BAUD = 9600
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        tx_o
);
    localparam logic [19:0] RESET_DIV = 20'(CLK_FREQ / RESET_BAUD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [19:0] divisor_q, divisor_d;
    logic [19:0] fdiv_q, fdiv_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        fpar_en_q, fpar_en_d;
    logic        fstop2_q, fstop2_d;
    logic        par_bit_q, par_bit_d;
    logic        par_en_q, par_en_d;
    logic        stop_bits_q, stop_bits_d;
    logic        tx_q, tx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [31:0] read_data_q, read_data_d;

    logic        wr_en, rd_en, soft_rst, data_wr;
    logic        pop, start_frame, q_empty, full, busy;
    logic [7:0]  q_head;
    logic        unused_bits;

    assign wr_en       = req_i & write_enable_i;
    assign rd_en       = req_i & ~write_enable_i;
    assign soft_rst    = wr_en && (addr_i == 32'h24) && write_data_i[0];
    assign data_wr     = wr_en && (addr_i == 32'h00);
    assign busy        = (state_q != IDLE) || !q_empty;
    assign unused_bits = ^write_data_i[31:20];
    assign tx_o        = tx_q;
    assign read_data_o = read_data_q;

`ifdef UART_TX_FIFO_EN
    // Extra pointer bit separates full from empty when the low bits match.
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[1:0] == rd_ptr_q[1:0]) && (wr_ptr_q[2] != rd_ptr_q[2]);
    assign q_head  = fifo_q[rd_ptr_q[1:0]];

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (data_wr && (!full || pop)) begin
            fifo_d[wr_ptr_q[1:0]] = write_data_i[7:0];
            wr_ptr_d              = wr_ptr_q + 3'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 3'd1;
        if (soft_rst) begin
            wr_ptr_d = 3'd0;
            rd_ptr_d = 3'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fifo_q   <= fifo_d;
        end
    end
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_data_q, hold_data_d;

    assign q_empty = !hold_valid_q;
    assign full    = busy;
    assign q_head  = hold_data_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (pop) hold_valid_d = 1'b0;
        if (data_wr && !busy) begin
            hold_valid_d = 1'b1;
            hold_data_d  = write_data_i[7:0];
        end
        if (soft_rst) hold_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
`endif

    // Transmit FSM; tx is registered so each level is launched on the transition edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        fdiv_d      = fdiv_q;
        fpar_en_d   = fpar_en_q;
        fstop2_d    = fstop2_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        case (state_q)
            IDLE: if (!q_empty) start_frame = 1'b1;
            START: begin
                if (cnt_q == 20'd0) begin
                    state_d   = DATA;
                    cnt_d     = fdiv_q - 20'd1;
                    bit_idx_d = 3'd0;
                    tx_d      = shreg_q[0];
                end else cnt_d = cnt_q - 20'd1;
            end
            DATA: begin
                if (cnt_q == 20'd0) begin
                    cnt_d = fdiv_q - 20'd1;
                    if (bit_idx_q == 3'd7) begin
                        if (fpar_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = fstop2_q;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else cnt_d = cnt_q - 20'd1;
            end
            PARITY: begin
                if (cnt_q == 20'd0) begin
                    state_d    = STOP;
                    cnt_d      = fdiv_q - 20'd1;
                    tx_d       = 1'b1;
                    stop_cnt_d = fstop2_q;
                end else cnt_d = cnt_q - 20'd1;
            end
            STOP: begin
                if (cnt_q == 20'd0) begin
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                        cnt_d      = fdiv_q - 20'd1;
                    end else if (!q_empty) start_frame = 1'b1;
                    else state_d = IDLE;
                end else cnt_d = cnt_q - 20'd1;
            end
            default: state_d = IDLE;
        endcase
        if (start_frame) begin
            pop       = 1'b1;
            state_d   = START;
            tx_d      = 1'b0;
            cnt_d     = divisor_q - 20'd1;
            fdiv_d    = divisor_q;
            fpar_en_d = par_en_q;
            fstop2_d  = stop_bits_q;
            shreg_d   = q_head;
            par_bit_d = ^q_head;
        end
        if (soft_rst) begin
            pop        = 1'b0;
            state_d    = IDLE;
            tx_d       = 1'b1;
            cnt_d      = 20'd0;
            bit_idx_d  = 3'd0;
            stop_cnt_d = 1'b0;
        end
    end

    always_comb begin
        divisor_d   = divisor_q;
        par_en_d    = par_en_q;
        stop_bits_d = stop_bits_q;
        read_data_d = read_data_q;
        if (wr_en) begin
            case (addr_i)
                32'h0C: if (!busy) divisor_d = (write_data_i[19:0] < 20'd2) ? 20'd2 : write_data_i[19:0];
                32'h10: par_en_d = write_data_i[0];
                32'h14: stop_bits_d = write_data_i[0];
                default: ;
            endcase
        end
        if (rd_en) begin
            case (addr_i)
                32'h08:  read_data_d = {31'd0, busy};
                32'h0C:  read_data_d = {12'd0, divisor_q};
                32'h10:  read_data_d = {31'd0, par_en_q};
                32'h14:  read_data_d = {31'd0, stop_bits_q};
                32'h18:  read_data_d = {31'd0, full};
                default: read_data_d = 32'd0;
            endcase
        end
        if (soft_rst) begin
            divisor_d   = RESET_DIV;
            par_en_d    = 1'b0;
            stop_bits_d = 1'b0;
            read_data_d = 32'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 20'd0;
            divisor_q   <= RESET_DIV;
            fdiv_q      <= RESET_DIV;
            bit_idx_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            fpar_en_q   <= 1'b0;
            fstop2_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop_bits_q <= 1'b0;
            tx_q        <= 1'b1;
            shreg_q     <= 8'd0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            fdiv_q      <= fdiv_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            fpar_en_q   <= fpar_en_d;
            fstop2_q    <= fstop2_d;
            par_bit_q   <= par_bit_d;
            par_en_q    <= par_en_d;
            stop_bits_q <= stop_bits_d;
            tx_q        <= tx_d;
            shreg_q     <= shreg_d;
            read_data_q <= read_data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Scoreboard bench for uart_tx_sb_ctrl: expected reads and expected tx frames are queued by the
// stimulus; independent monitors compare bus read data and the tx_o waveform cycle by cycle.
module tb_uart_tx_sb_ctrl;
    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr, wdata, rdata;
    logic        tx;

    uart_tx_sb_ctrl #(.CLK_FREQ(10_000_000), .RESET_BAUD(9600)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .write_enable_i(we),
        .addr_i(addr), .write_data_i(wdata), .read_data_o(rdata), .tx_o(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         div;
        bit         par;
        bit         stop2;
        bit         pbit;
        bit         contig;
        int         abort_at;
        int         start_cyc;
    } frame_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_wr_cyc = 0;
    frame_t      exp_frames[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        last_wr_cyc = cyc;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(nm);
        req = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b, input int div, input bit par, input bit stop2,
                              input bit pbit, input bit contig, input int abort_at, input int start_cyc);
        frame_t f;
        f.b = b; f.div = div; f.par = par; f.stop2 = stop2; f.pbit = pbit;
        f.contig = contig; f.abort_at = abort_at; f.start_cyc = start_cyc;
        exp_frames.push_back(f);
    endtask

    task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Read monitor: a read sampled at an edge must show its data right after that edge.
    bit rd_pend;
    initial begin
        forever begin
            @(posedge clk);
            rd_pend = req && !we && !rst;
            @(negedge clk);
            if (rd_pend) begin
                n_tests++;
                if (rd_exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_unexpected: got 0x%08h with no expected value queued", rdata);
                end else begin
                    logic [31:0] e;
                    string       nm;
                    e  = rd_exp_q.pop_front();
                    nm = rd_name_q.pop_front();
                    if (rdata !== e) begin
                        n_fail++;
                        $display("FAIL %s: read 0x%08h, expected 0x%08h", nm, rdata, e);
                    end else $display("[TB] read %s = 0x%08h ok", nm, rdata);
                end
            end
        end
    end

    // Tx monitor: compares every cycle of a frame against the expected bit levels.
    frame_t cur;
    bit     active = 1'b0;
    bit     prev_tx = 1'b1;
    bit     bad;
    int     lv[12];
    int     nlv, pos, gap, bad_pos, bad_exp;
    logic   bad_act;
    initial begin
        gap = 0;
        forever begin
            @(negedge clk);
            if (!active && tx === 1'b0 && prev_tx === 1'b1) begin
                if (exp_frames.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: tx fell at cycle %0d, expected no frame", cyc);
                end else begin
                    cur = exp_frames.pop_front();
                    nlv = 0;
                    lv[nlv] = 0; nlv++;
                    for (int k = 0; k < 8; k++) begin
                        lv[nlv] = int'(cur.b[k]); nlv++;
                    end
                    if (cur.par) begin
                        lv[nlv] = int'(cur.pbit); nlv++;
                    end
                    lv[nlv] = 1; nlv++;
                    if (cur.stop2) begin
                        lv[nlv] = 1; nlv++;
                    end
                    active = 1'b1; pos = 0; bad = 1'b0;
                    if (cur.contig) begin
                        n_tests++;
                        if (gap != 0) begin
                            n_fail++;
                            $display("FAIL gap_0x%02h: idle gap %0d cycles, expected 0", cur.b, gap);
                        end
                    end
                    if (cur.start_cyc >= 0) begin
                        n_tests++;
                        if (cyc != cur.start_cyc) begin
                            n_fail++;
                            $display("FAIL start_0x%02h: start at cycle %0d, expected %0d", cur.b, cyc, cur.start_cyc);
                        end
                    end
                end
            end else if (!active) gap++;
            if (active) begin
                if (cur.abort_at >= 0 && pos == cur.abort_at) begin
                    n_tests++;
                    if (tx !== 1'b1 || bad) begin
                        n_fail++;
                        $display("FAIL abort_0x%02h: tx=%b at abort cycle %0d (expected 1), early mismatch=%0b",
                                 cur.b, tx, pos, bad);
                    end else $display("[TB] frame 0x%02h aborted at cycle %0d, tx high", cur.b, pos);
                    active = 1'b0; gap = 0;
                end else begin
                    if (tx !== lv[pos / cur.div][0] && !bad) begin
                        bad = 1'b1; bad_pos = pos; bad_act = tx; bad_exp = lv[pos / cur.div];
                    end
                    pos++;
                    if (pos == cur.div * nlv) begin
                        n_tests++;
                        if (bad) begin
                            n_fail++;
                            $display("FAIL frame_0x%02h: tx=%b at frame cycle %0d, expected %0d",
                                     cur.b, bad_act, bad_pos, bad_exp);
                        end else $display("[TB] frame 0x%02h ok (%0d cycles)", cur.b, pos);
                        active = 1'b0; gap = 0;
                    end
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_tx", {31'd0, tx}, 32'd1);
        check_now("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        bus_read(32'h0C, 32'd1041, "rst_divisor");
        bus_read(32'h08, 32'd0, "rst_busy");
        bus_read(32'h18, 32'd0, "rst_full");
        bus_read(32'h10, 32'd0, "rst_parity_en");
        bus_read(32'h14, 32'd0, "rst_stop_bits");

        // 0x55, divisor 4, no parity, one stop bit; mid-frame config writes must not disturb it
        bus_write(32'h0C, 32'd4);
        bus_read(32'h0C, 32'd4, "div_set");
        bus_write(32'h00, 32'h55);
        push_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, -1, last_wr_cyc + 1);
        bus_read(32'h08, 32'd1, "busy_after_write");
        bus_write(32'h0C, 32'd8);
        bus_read(32'h0C, 32'd4, "div_write_ignored");
        bus_write(32'h10, 32'd1);
        idle(36);
        bus_read(32'h08, 32'd1, "busy_last_stop_cycle");
        bus_read(32'h08, 32'd0, "busy_cleared_at_40");

        // 0x07 with even parity (three ones -> 1) and two stop bits at divisor 3: 36 cycles
        bus_write(32'h14, 32'd1);
        bus_write(32'h0C, 32'd3);
        bus_read(32'h10, 32'd1, "parity_en_rb");
        bus_read(32'h14, 32'd1, "stop_bits_rb");
        bus_write(32'h00, 32'h07);
        push_frame(8'h07, 3, 1'b1, 1'b1, 1'b1, 1'b0, -1, last_wr_cyc + 1);
        bus_read(32'h08, 32'd1, "busy_parity_frame");
        idle(35);
        bus_read(32'h08, 32'd1, "busy_at_36");
        bus_read(32'h08, 32'd0, "busy_cleared_at_37");

        // divisor clamp and field width
        bus_write(32'h0C, 32'd1);
        bus_read(32'h0C, 32'd2, "div_clamp_1");
        bus_write(32'h0C, 32'd0);
        bus_read(32'h0C, 32'd2, "div_clamp_0");
        bus_write(32'h0C, 32'hFFF0_0005);
        bus_read(32'h0C, 32'd5, "div_mask_20b");

        // burst of five data writes at divisor 2
        bus_write(32'h10, 32'd0);
        bus_write(32'h14, 32'd0);
        bus_write(32'h0C, 32'd2);
        bus_write(32'h00, 32'hA1);
        push_frame(8'hA1, 2, 1'b0, 1'b0, 1'b0, 1'b0, -1, last_wr_cyc + 1);
        for (int k = 1; k < 5; k++) begin
            bus_write(32'h00, 32'hA1 + 32'(k));
`ifdef UART_TX_FIFO_EN
            push_frame(8'hA1 + 8'(k), 2, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
`endif
        end
        bus_read(32'h18, 32'd1, "full_after_burst");
        idle(110);
        bus_read(32'h18, 32'd0, "full_after_drain");
        bus_read(32'h08, 32'd0, "busy_after_drain");

        // asynchronous reset in the middle of the data bits
        bus_write(32'h0C, 32'd4);
        bus_write(32'h00, 32'h3C);
        push_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b0, 19, last_wr_cyc + 1);
        idle(20);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus_read(32'h08, 32'd0, "busy_after_rst");
        bus_read(32'h0C, 32'd1041, "div_after_rst");
        idle(100);

        // unmapped read, then soft reset through offset 0x24 mid-frame
        bus_read(32'h30, 32'd0, "unmapped_read");
        bus_write(32'h0C, 32'd4);
        bus_write(32'h14, 32'd1);
        bus_write(32'h00, 32'hC3);
        push_frame(8'hC3, 4, 1'b0, 1'b1, 1'b0, 1'b0, 9, last_wr_cyc + 1);
        idle(9);
        bus_write(32'h24, 32'd1);
        bus_read(32'h0C, 32'd1041, "div_after_soft_rst");
        bus_read(32'h14, 32'd0, "stop_after_soft_rst");
        bus_read(32'h08, 32'd0, "busy_after_soft_rst");
        bus_read(32'h00, 32'd0, "data_reg_reads_0");
        idle(60);

        n_tests++;
        if (exp_frames.size() != 0 || rd_exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained: %0d frames and %0d reads left, expected 0 and 0",
                     exp_frames.size(), rd_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
